// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer blocks: the common layer sequencing
// states and a width helper for index counters and RAM addresses.
package cnn_pkg;

   // Sequencing states shared by the streaming layer controllers.
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      EMIT,
      DONE
   } layer_state_e;

   // Bits needed to index n items; never below 1 so one-entry ranges still get a port.
   function automatic int clog2w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_reg.sv
// Shift register used as a word packer: each enabled cycle the new chunk
// enters at the top and older chunks move towards bit 0, so after SIZE/SHIFT_AMT
// pushes the first chunk sits in the lowest bits.
module shift_reg #(
   parameter int SIZE      = 32,
   parameter int SHIFT_AMT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [SHIFT_AMT-1:0] din,
   output logic [SIZE-1:0]      q
);

   generate
      if (SIZE == SHIFT_AMT) begin : g_single
         // One chunk per word: the register simply loads the new chunk.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) q <= '0;
            else if (en) q <= din;
         end
      end else begin : g_multi
         // New chunk at the top, everything else slides down one chunk.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) q <= '0;
            else if (en) q <= {din, q[SIZE-1:SHIFT_AMT]};
         end
      end
   endgenerate

endmodule

// File: rtl/upsample_layer.sv
// Nearest-neighbour upsampler: reads a packed source feature map from a
// synchronous-read RAM and writes the SCALE x SCALE replicated map to a
// destination RAM, one packed word per write, addresses strictly ascending.
// Each source row is re-read once per output row, so no line buffer is kept.
module upsample_layer
   import cnn_pkg::*;
#(
   parameter int INPUT_X              = 4,
   parameter int INPUT_Y              = 4,
   parameter int SCALE                = 2,
   parameter int BIT_WIDTH            = 16,
   parameter int RAM_WIDTH_MULTIPLIER = 2
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         start,
   input  logic [BIT_WIDTH*RAM_WIDTH_MULTIPLIER-1:0]    data_rd,
   output logic [clog2w(INPUT_X*INPUT_Y/RAM_WIDTH_MULTIPLIER)-1:0] addr_rd,
   output logic [BIT_WIDTH*RAM_WIDTH_MULTIPLIER-1:0]    data_wr,
   output logic [clog2w(INPUT_X*SCALE*INPUT_Y*SCALE/RAM_WIDTH_MULTIPLIER)-1:0] addr_wr,
   output logic                                         wren,
   output logic                                         done
);

   localparam int M   = RAM_WIDTH_MULTIPLIER;
   localparam int WPR = INPUT_X / M;   // source words per source row
   localparam int RA  = clog2w(INPUT_X*INPUT_Y/M);
   localparam int WA  = clog2w(INPUT_X*SCALE*INPUT_Y*SCALE/M);
   localparam int XW  = clog2w(WPR);
   localparam int YW  = clog2w(INPUT_Y);
   localparam int SW  = clog2w(SCALE);
   localparam int KW  = clog2w(M);

   localparam logic [XW-1:0] X_LAST = XW'(WPR - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(INPUT_Y - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);
   localparam logic [KW-1:0] K_LAST = KW'(M - 1);
   localparam logic [WA-1:0] A_LAST = WA'(INPUT_X*SCALE*INPUT_Y*SCALE/M - 1);

   // A source row must split into whole RAM words.
   generate
      if (INPUT_X % M != 0) begin : g_bad_width
         $error("upsample_layer: INPUT_X must be a multiple of RAM_WIDTH_MULTIPLIER");
      end
   endgenerate

   layer_state_e           state_q, state_n;
   logic [XW-1:0]          wx_q, wx_n;     // word within the source row
   logic [YW-1:0]          sy_q, sy_n;     // source row
   logic [SW-1:0]          rep_q, rep_n;   // which copy of the source row
   logic [KW-1:0]          k_q;            // source pixel within the word
   logic [SW-1:0]          r_q;            // horizontal repeat of that pixel
   logic [KW-1:0]          p_q;            // pixels already in the packer
   logic [BIT_WIDTH*M-1:0] src_q;
   logic [BIT_WIDTH-1:0]   pix;
   logic [RA-1:0]          rd_addr_n;
   logic                   push, restart, last_emit, last_word;

   // Sequencing: next state and per-cycle strobes.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n   = state_q;
      push      = 1'b0;
      restart   = 1'b0;
      last_emit = (k_q == K_LAST) && (r_q == S_LAST);
      last_word = (wx_q == X_LAST) && (rep_q == S_LAST) && (sy_q == Y_LAST);
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_n = FETCH;
               restart = 1'b1;
            end
         end
         FETCH: state_n = WAIT;
         WAIT:  state_n = EMIT;
         EMIT: begin
            push = 1'b1;
            if (last_emit) state_n = last_word ? DONE : FETCH;
         end
         default: state_n = IDLE;
      endcase
   end

   // Next source-word position, advanced once each word has been fully emitted.
   always_comb begin
      wx_n  = wx_q;
      sy_n  = sy_q;
      rep_n = rep_q;
      if (restart) begin
         wx_n  = '0;
         sy_n  = '0;
         rep_n = '0;
      end else if (push && last_emit && !last_word) begin
         if (wx_q == X_LAST) begin
            wx_n = '0;
            if (rep_q == S_LAST) begin
               rep_n = '0;
               sy_n  = sy_q + 1'b1;
            end else begin
               rep_n = rep_q + 1'b1;
            end
         end else begin
            wx_n = wx_q + 1'b1;
         end
      end
   end

   assign rd_addr_n = RA'(int'(sy_n) * WPR + int'(wx_n));
   assign pix       = src_q[int'(k_q)*BIT_WIDTH +: BIT_WIDTH];

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_n;
   end

   // Counters, read address, source word capture and the write strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wx_q    <= '0;
         sy_q    <= '0;
         rep_q   <= '0;
         k_q     <= '0;
         r_q     <= '0;
         p_q     <= '0;
         src_q   <= '0;
         addr_rd <= '0;
         addr_wr <= '0;
         wren    <= 1'b0;
         done    <= 1'b0;
      end else begin
         wx_q  <= wx_n;
         sy_q  <= sy_n;
         rep_q <= rep_n;
         // Address is presented during FETCH; the RAM answers during WAIT.
         if (state_n == FETCH) addr_rd <= rd_addr_n;
         if (state_q == WAIT)  src_q   <= data_rd;
         if (restart) begin
            k_q <= '0;
            r_q <= '0;
            p_q <= '0;
         end else if (push) begin
            if (r_q == S_LAST) begin
               r_q <= '0;
               k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
            end else begin
               r_q <= r_q + 1'b1;
            end
            p_q <= (p_q == K_LAST) ? '0 : p_q + 1'b1;
         end
         // The packer holds a complete word the cycle after its last pixel enters.
         wren <= push && (p_q == K_LAST);
         if (restart) addr_wr <= '0;
         else if (wren && (addr_wr != A_LAST)) addr_wr <= addr_wr + 1'b1;
         done <= (state_n == DONE);
      end
   end

   shift_reg #(
      .SIZE      (M*BIT_WIDTH),
      .SHIFT_AMT (BIT_WIDTH)
   ) u_pack (
      .clk (clk),
      .rst (rst),
      .en  (push),
      .din (pix),
      .q   (data_wr)
   );

endmodule

// File: tb/tb_upsample_layer.sv
// Bench for upsample_layer: a default 4x4 x2 instance and a SCALE=1 instance,
// each with a synchronous-read source RAM model and a write monitor. Expected
// images come from the nearest-neighbour rule applied to the source array.
module tb_upsample_layer;

   localparam int IX = 4, IY = 4, BW = 16, M = 2, S = 2;
   localparam int OX = IX*S, OY = IY*S;
   localparam int N_IN    = IX*IY/M;
   localparam int N_OUT_A = OX*OY/M;
   localparam int WPR     = IX/M;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } vec_t;

   logic          clk = 1'b0, rst = 1'b0, start_a = 1'b0, start_b = 1'b0;
   logic [31:0]   data_rd_a, data_rd_b, data_wr_a, data_wr_b;
   logic [2:0]    addr_rd_a, addr_rd_b, addr_wr_b;
   logic [4:0]    addr_wr_a;
   logic          wren_a, wren_b, done_a, done_b;

   logic [BW-1:0] src_a [IY][IX];
   logic [31:0]   mem_a [N_IN];
   logic [31:0]   mem_b [N_IN];
   logic [31:0]   img_a [N_OUT_A];
   int            got_addr [$];
   logic [31:0]   got_data [$];
   int            done_cyc;
   int            n_checks = 0, n_fail = 0;
   vec_t          tbl [6];

   always #5 clk = ~clk;

   // Synchronous-read source RAMs.
   always @(posedge clk) begin
      data_rd_a <= mem_a[addr_rd_a];
      data_rd_b <= mem_b[addr_rd_b];
   end

   upsample_layer u_dut (
      .clk(clk), .rst(rst), .start(start_a), .data_rd(data_rd_a), .addr_rd(addr_rd_a),
      .data_wr(data_wr_a), .addr_wr(addr_wr_a), .wren(wren_a), .done(done_a)
   );

   upsample_layer #(.SCALE(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start_b), .data_rd(data_rd_b), .addr_rd(addr_rd_b),
      .data_wr(data_wr_b), .addr_wr(addr_wr_b), .wren(wren_b), .done(done_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_src_a(input bit rnd);
      for (int y = 0; y < IY; y++)
         for (int x = 0; x < IX; x++) begin
            logic [BW-1:0] v;
            v = rnd ? BW'($urandom) : BW'(16*y + x + 1);
            src_a[y][x] = v;
            mem_a[(y*IX + x)/M][((y*IX + x)%M)*BW +: BW] = v;
         end
   endtask

   // Output pixel p (row-major) copies source pixel (ox/S, oy/S).
   function automatic logic [31:0] exp_word_a(input int a);
      logic [31:0] w;
      for (int j = 0; j < M; j++) begin
         int p;
         p = a*M + j;
         w[j*BW +: BW] = src_a[(p/OX)/S][(p%OX)/S];
      end
      return w;
   endfunction

   // Read i: every source row is read S times in a row, WPR words each time.
   function automatic int exp_rd(input int i);
      return (i/(S*WPR))*WPR + i%WPR;
   endfunction

   task automatic run_pass_a(input bit mid_start);
      got_addr.delete();
      got_data.delete();
      for (int a = 0; a < N_OUT_A; a++) img_a[a] = 'x;
      done_cyc = -1;
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (cyc % 6 == 0 && cyc < 6*N_IN*S)
            check($sformatf("addr_rd[%0d]", cyc/6), 64'(addr_rd_a), 64'(exp_rd(cyc/6)));
         if (wren_a) begin
            got_addr.push_back(int'(addr_wr_a));
            got_data.push_back(data_wr_a);
            img_a[addr_wr_a] = data_wr_a;
         end
         if (done_a && done_cyc < 0) done_cyc = cyc;
         start_a = mid_start && (cyc >= 40) && (cyc <= 43);
         if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
         @(posedge clk);
         #1;
      end
      start_a = 1'b0;
      check("done_latency", 64'(done_cyc), 64'(6*N_IN*S));
      check("done_held", 64'(done_a), 64'd1);
   endtask

   task automatic check_writes_a(input string tag);
      check({tag, "_count"}, 64'(got_addr.size()), 64'(N_OUT_A));
      for (int k = 0; k < got_addr.size(); k++) begin
         check($sformatf("%s_addr[%0d]", tag, k), 64'(got_addr[k]), 64'(k));
         check($sformatf("%s_data[%0d]", tag, k), 64'(got_data[k]), 64'(exp_word_a(k)));
      end
   endtask

   initial begin
      int n;
      int extra;

      // Reset state.
      #12;
      check("rst_wren",    64'(wren_a),    64'd0);
      check("rst_done",    64'(done_a),    64'd0);
      check("rst_addr_rd", 64'(addr_rd_a), 64'd0);
      check("rst_addr_wr", 64'(addr_wr_a), 64'd0);
      check("rst_data_wr", 64'(data_wr_a), 64'd0);
      check("rst_wren_s1", 64'(wren_b),    64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_no_done", 64'(done_a), 64'd0);

      // Reference pattern 16*y+x+1 with hand-derived words.
      tbl[0] = '{0,  32'h0001_0001};
      tbl[1] = '{1,  32'h0002_0002};
      tbl[2] = '{3,  32'h0004_0004};
      tbl[3] = '{4,  32'h0001_0001};
      tbl[4] = '{8,  32'h0011_0011};
      tbl[5] = '{31, 32'h0034_0034};
      load_src_a(1'b0);
      check("src_word0", 64'(mem_a[0]), 64'h0002_0001);
      run_pass_a(1'b0);
      check_writes_a("pattern");
      for (int i = 0; i < 6; i++)
         check($sformatf("tbl_addr%0d", tbl[i].addr), 64'(img_a[tbl[i].addr]), 64'(tbl[i].data));

      // Random source image.
      load_src_a(1'b1);
      run_pass_a(1'b0);
      check_writes_a("random");

      // start pulsed during EMIT, FETCH and WAIT must be ignored.
      load_src_a(1'b1);
      run_pass_a(1'b1);
      check_writes_a("midstart");

      // Reset after the 10th write.
      load_src_a(1'b1);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      n = 0;
      for (int c = 0; c < 200 && n < 10; c++) begin
         if (wren_a) n++;
         if (n < 10) begin
            @(posedge clk);
            #1;
         end
      end
      check("writes_before_reset", 64'(n), 64'd10);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_wren",    64'(wren_a),    64'd0);
      check("midrst_done",    64'(done_a),    64'd0);
      check("midrst_addr_rd", 64'(addr_rd_a), 64'd0);
      check("midrst_addr_wr", 64'(addr_wr_a), 64'd0);
      check("midrst_data_wr", 64'(data_wr_a), 64'd0);
      extra = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (wren_a) extra++;
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (wren_a) extra++;
      end
      check("wren_after_reset", 64'(extra), 64'd0);
      check("idle_after_reset", 64'(done_a), 64'd0);
      run_pass_a(1'b0);
      check_writes_a("post_reset");

      // SCALE=1: destination image equals the source.
      for (int a = 0; a < N_IN; a++) mem_b[a] = $urandom;
      got_addr.delete();
      got_data.delete();
      done_cyc = -1;
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (wren_b) begin
            got_addr.push_back(int'(addr_wr_b));
            got_data.push_back(data_wr_b);
         end
         if (done_b && done_cyc < 0) done_cyc = cyc;
         if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
         @(posedge clk);
         #1;
      end
      check("s1_done_seen", 64'(done_cyc >= 0), 64'd1);
      check("s1_count", 64'(got_addr.size()), 64'(N_IN));
      for (int k = 0; k < got_addr.size(); k++) begin
         check($sformatf("s1_addr[%0d]", k), 64'(got_addr[k]), 64'(k));
         check($sformatf("s1_data[%0d]", k), 64'(got_data[k]), 64'(mem_b[k % N_IN]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/upsample_layer.md
UPSAMPLE_LAYER -- requirements
Module: upsample_layer

Interface
REQ-001 SHALL have parameter INPUT_X, default 4, meaning source feature-map width in pixels.
REQ-002 SHALL have parameter INPUT_Y, default 4, meaning source feature-map height in pixels.
REQ-003 SHALL have parameter SCALE, default 2, meaning nearest-neighbour replication factor in X and Y.
REQ-004 SHALL have parameter BIT_WIDTH, default 16, meaning pixel width in bits.
REQ-005 SHALL have parameter RAM_WIDTH_MULTIPLIER (M), default 2, meaning pixels per RAM word.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, meaning begin one full upsample pass.
REQ-009 SHALL have port data_rd, input, BIT_WIDTH*M, meaning source RAM read data; pixel k at bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-010 SHALL have port addr_rd, output, RA = max(1, clog2(INPUT_X*INPUT_Y/M)), meaning source RAM word address.
REQ-011 SHALL have port data_wr, output, BIT_WIDTH*M, meaning destination RAM write data, same packing as data_rd.
REQ-012 SHALL have port addr_wr, output, WA = max(1, clog2(INPUT_X*SCALE*INPUT_Y*SCALE/M)), meaning destination RAM word address.
REQ-013 SHALL have port wren, output, 1, meaning single-cycle destination write strobe.
REQ-014 SHALL have port done, output, 1, meaning pass complete.

Function
REQ-015 SHALL produce the map OX = INPUT_X*SCALE by OY = INPUT_Y*SCALE with out(ox,oy) = in(ox/SCALE, oy/SCALE), row-major, integer division.
REQ-016 SHALL require INPUT_X divisible by M; violation SHALL be a static elaboration error.
REQ-017 SHALL treat the source RAM as synchronous read: data_rd valid exactly one cycle after addr_rd is registered.
REQ-018 SHALL implement FSM states IDLE, FETCH, WAIT, EMIT, DONE.
REQ-019 SHALL move IDLE->FETCH on start=1; start SHALL be ignored in FETCH, WAIT and EMIT.
REQ-020 SHALL in FETCH drive addr_rd = (oy/SCALE)*(INPUT_X/M) + word index within the row, then move to WAIT.
REQ-021 SHALL in WAIT capture data_rd into a source word register, then move to EMIT.
REQ-022 SHALL in EMIT push one output pixel per cycle into the output packer: each of the M source pixels in ascending k order, repeated SCALE times consecutively (M*SCALE cycles).
REQ-023 SHALL re-read each source row once per output row (SCALE reads per source word); no line buffer.
REQ-024 SHALL, on the cycle after the M-th pixel of an output word enters the packer, assert wren for exactly one cycle with registered data_wr and addr_wr.
REQ-025 SHALL write addr_wr sequentially from 0 to OX*OY/M-1, one write per address, no gaps or repeats.
REQ-026 SHALL after EMIT go to FETCH for the next source word, advancing to the next output row at row end, or to DONE after the final write.
REQ-027 SHALL hold done=1 in DONE until start=1, which clears done in the same cycle it enters FETCH and begins a fresh pass at addresses 0.
REQ-028 SHALL keep all counters wrap-free: index widths sized so that terminal values (OX*OY/M-1, INPUT_X*INPUT_Y/M-1) are representable.

Reset
REQ-029 SHALL on rst=0 immediately force state IDLE and addr_rd, addr_wr, data_wr, wren, done, all counters and the packer to 0.
REQ-030 SHALL, on reset assertion mid-pass, issue no further wren; after release it SHALL wait in IDLE for start.

Structure
REQ-031 SHALL take the FSM state enum and a clog2-floor-1 width helper from the shared cnn package, alongside the layer modules that use them.
REQ-032 SHALL implement output packing by instantiating the existing shift_reg sub-module (SIZE = M*BIT_WIDTH, SHIFT_AMT = BIT_WIDTH), oriented so the first pushed pixel lands in bits [BIT_WIDTH-1:0].

Verification (defaults: 4x4, SCALE=2, 16-bit, M=2; source pixel value = 16*y+x+1)
REQ-033 SHALL check: one start -> exactly 32 wren pulses, addr_wr 0..31 in order, done=1 after the last pulse.
REQ-034 SHALL check: source word 0 = {16'h0002,16'h0001} -> addr_wr 0 data {0001,0001}, addr_wr 1 data {0002,0002}, addr_wr 4 data {0001,0001}.
REQ-035 SHALL check: addr_rd sequence 0,1,0,1,2,3,2,3,... (each source row read twice, 16 reads total) and 6 cycles per source word (FETCH+WAIT+4 EMIT).
REQ-036 SHALL check: start pulsed again mid-pass -> ignored, write count remains 32.
REQ-037 SHALL check: rst=0 asserted after the 10th write -> all outputs 0 same cycle, no further wren; later start -> full 32-write pass from addr 0.
REQ-038 SHALL check: SCALE=1 -> output RAM image identical to the source, 8 writes.
